// File: rtl/if_id_stage_pkg.sv
// Shared constants and state encodings for the IF/ID pipeline register.
// Consumers import if_id_stage_pkg::*.
package if_id_stage_pkg;

  localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_1000;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_ONE   = 2'd1,
    IFID_FULL  = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake; 1-cycle latency, flush discards held entries.
// IF_ID_STAGE_SKID_EN: two-entry skid buffer with registered in_ready_o; otherwise a single register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  ifid_state_e       r_state;
  ifid_state_e       w_next_state;
  logic [PC_W-1:0]   r_main_pc;
  logic [INST_W-1:0] r_main_inst;
  logic              r_in_rdy;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_load_main;
`ifdef IF_ID_STAGE_SKID_EN
  logic [PC_W-1:0]   r_skid_pc;
  logic [INST_W-1:0] r_skid_inst;
  logic              w_load_skid;
  logic              w_skid_to_main;
`endif

  assign out_valid_o = (r_state != IFID_EMPTY);
  assign w_in_xfer   = in_valid_i && in_ready_o;
  assign w_out_xfer  = out_valid_o && out_ready_i;
  assign pc_o        = r_main_pc;
  assign inst_o      = out_valid_o ? r_main_inst : INST_W'(ZERO_WORD);

`ifdef IF_ID_STAGE_SKID_EN
  assign in_ready_o = r_in_rdy;
`else
  // r_in_rdy only masks the reset cycle; otherwise ready follows the consumer.
  assign in_ready_o = r_in_rdy && (!out_valid_o || out_ready_i);
`endif

  always_comb begin
    w_next_state   = r_state;
    w_load_main    = 1'b0;
`ifdef IF_ID_STAGE_SKID_EN
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
`endif
    case (r_state)
      IFID_EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = IFID_ONE;
          w_load_main  = 1'b1;
        end
      end
      IFID_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_out_xfer) begin
          w_next_state = IFID_EMPTY;
`ifdef IF_ID_STAGE_SKID_EN
        end else if (w_in_xfer) begin
          w_next_state = IFID_FULL;
          w_load_skid  = 1'b1;
`endif
        end
      end
`ifdef IF_ID_STAGE_SKID_EN
      IFID_FULL: begin
        if (w_out_xfer) begin
          w_next_state   = IFID_ONE;
          w_skid_to_main = 1'b1;
        end
      end
`endif
      default: w_next_state = IFID_EMPTY;
    endcase
    // Redirect wins over everything; main is not reloaded so pc_o keeps its last value.
    if (flush_i) begin
      w_next_state   = IFID_EMPTY;
      w_load_main    = 1'b0;
`ifdef IF_ID_STAGE_SKID_EN
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= IFID_EMPTY;
      r_main_pc   <= RESET_PC;
      r_main_inst <= INST_W'(ZERO_WORD);
      r_in_rdy    <= 1'b0;
`ifdef IF_ID_STAGE_SKID_EN
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_load_main) begin
        r_main_pc   <= pc_i;
        r_main_inst <= inst_i;
      end
`ifdef IF_ID_STAGE_SKID_EN
      r_in_rdy <= (w_next_state != IFID_FULL);
      if (w_skid_to_main) begin
        r_main_pc   <= r_skid_pc;
        r_main_inst <= r_skid_inst;
      end
      if (w_load_skid) begin
        r_skid_pc   <= pc_i;
        r_skid_inst <= inst_i;
      end
`else
      r_in_rdy <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, streaming, backpressure, flush, reset while holding data.
// Expectations adapt to whether IF_ID_STAGE_SKID_EN is defined.
module tb_if_id_stage;

`ifdef IF_ID_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [31:0] EXP_RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int n_checks = 0;
  int n_errors = 0;

  if_id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid_i  = v;
    pc_i        = pc;
    inst_i      = inst;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc();
    cyc();
    // reset dominates a simultaneous flush
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_pc",        pc_o,   EXP_RESET_PC);
    chk("rst_inst",      inst_o, 32'h0);
    chk("rst_in_ready",  {31'd0, in_ready_o}, 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc();
    chk("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("post_rst_valid",    {31'd0, out_valid_o}, 32'd0);

    // streaming
    drive(1'b1, 32'h0, NOP, 1'b1, 1'b0);
    chk("s0_in_ready", {31'd0, in_ready_o}, 32'd1);
    cyc();
    drive(1'b1, 32'h4, NOP, 1'b1, 1'b0);
    chk("s1_valid",    {31'd0, out_valid_o}, 32'd1);
    chk("s1_pc",       pc_o, 32'h0);
    chk("s1_inst",     inst_o, NOP);
    chk("s1_in_ready", {31'd0, in_ready_o}, 32'd1);
    cyc();
    drive(1'b1, 32'h8, NOP, 1'b1, 1'b0);
    chk("s2_pc",       pc_o, 32'h4);
    chk("s2_valid",    {31'd0, out_valid_o}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("s3_pc",       pc_o, 32'h8);
    chk("s3_valid",    {31'd0, out_valid_o}, 32'd1);
    cyc();
    chk("s4_valid",    {31'd0, out_valid_o}, 32'd0);
    chk("s4_inst_nop", inst_o, 32'h0);
    chk("s4_pc_kept",  pc_o, 32'h8);

    // backpressure
    drive(1'b1, 32'h10, 32'hA10, 1'b0, 1'b0);
    chk("b1_in_ready", {31'd0, in_ready_o}, 32'd1);
    cyc();
    drive(1'b1, 32'h14, 32'hA14, 1'b0, 1'b0);
    chk("b2_in_ready", {31'd0, in_ready_o}, SKID ? 32'd1 : 32'd0);
    chk("b2_pc",       pc_o, 32'h10);
    cyc();
    drive(1'b1, SKID ? 32'h18 : 32'h14, SKID ? 32'hA18 : 32'hA14, 1'b0, 1'b0);
    chk("b3_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("b3_pc_stable",   pc_o, 32'h10);
    chk("b3_inst_stable", inst_o, 32'hA10);
    cyc();
    drive(1'b1, SKID ? 32'h18 : 32'h14, SKID ? 32'hA18 : 32'hA14, 1'b1, 1'b0);
    chk("b4_in_ready", {31'd0, in_ready_o}, SKID ? 32'd0 : 32'd1);
    chk("b4_pc",       pc_o, 32'h10);
    cyc();
    drive(1'b1, 32'h18, 32'hA18, 1'b1, 1'b0);
    chk("b5_pc",       pc_o, 32'h14);
    chk("b5_inst",     inst_o, 32'hA14);
    chk("b5_in_ready", {31'd0, in_ready_o}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("b6_pc",       pc_o, 32'h18);
    chk("b6_inst",     inst_o, 32'hA18);
    cyc();
    chk("b7_valid",    {31'd0, out_valid_o}, 32'd0);

    // flush while holding entries
    drive(1'b1, 32'h30, 32'hA30, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h34, 32'hA34, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h20, 32'hA20, 1'b0, 1'b1);
    chk("f_pre_pc", pc_o, 32'h30);
    cyc();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("f_valid",    {31'd0, out_valid_o}, 32'd0);
    chk("f_inst",     inst_o, 32'h0);
    chk("f_pc_kept",  pc_o, 32'h30);
    chk("f_in_ready", {31'd0, in_ready_o}, 32'd1);
    cyc();
    chk("f_no_emit",  {31'd0, out_valid_o}, 32'd0);
    cyc();
    chk("f_no_emit2", {31'd0, out_valid_o}, 32'd0);

    // reset while holding entries
    drive(1'b1, 32'h40, 32'hA40, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h44, 32'hA44, 1'b0, 1'b0);
    cyc();
    chk("r_pre_pc", pc_o, 32'h40);
    rst_n = 1'b1;
    drive(1'b1, 32'h48, 32'hA48, 1'b0, 1'b0);
    cyc();
    chk("r_valid",    {31'd0, out_valid_o}, 32'd0);
    chk("r_pc",       pc_o, EXP_RESET_PC);
    chk("r_inst",     inst_o, 32'h0);
    chk("r_in_ready", {31'd0, in_ready_o}, 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("r_after_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("r_after_valid",    {31'd0, out_valid_o}, 32'd0);
    cyc();
    chk("r_no_survivor",    {31'd0, out_valid_o}, 32'd0);
    chk("r_pc_held",        pc_o, EXP_RESET_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter PC_W, default 32, width of program-counter field.
REQ-002 Parameter INST_W, default 32, width of instruction field.
REQ-003 Parameter RESET_PC, default CPU_RESET_ADDR, value driven on pc_o while out_valid_o is low after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 in_valid_i  input  1  upstream (IF) holds a valid pc/inst pair.
REQ-007 in_ready_o  output  1  stage can accept a pair this cycle.
REQ-008 pc_i  input  PC_W  fetched instruction address.
REQ-009 inst_i  input  INST_W  fetched instruction word.
REQ-010 flush_i  input  1  discard all held entries (branch/exception redirect).
REQ-011 out_valid_o  output  1  pc_o/inst_o valid toward ID.
REQ-012 out_ready_i  input  1  ID consumes the pair this cycle.
REQ-013 pc_o  output  PC_W  held address.
REQ-014 inst_o  output  INST_W  held instruction; ZERO_WORD (NOP bubble) when out_valid_o low.

Function
REQ-015 Transfer in occurs when in_valid_i && in_ready_o; transfer out when out_valid_o && out_ready_i.
REQ-016 Two-entry storage: main register (drives outputs) and skid register; states EMPTY, ONE, FULL.
REQ-017 EMPTY: in-transfer -> ONE, data into main; in_ready_o=1, out_valid_o=0.
REQ-018 ONE: in and out both -> ONE, main reloaded; in only -> FULL, data into skid; out only -> EMPTY.
REQ-019 FULL: in_ready_o=0; out-transfer -> ONE, skid moves to main.
REQ-020 in_ready_o SHALL be a registered signal (no combinational path from out_ready_i).
REQ-021 Latency: pair accepted in cycle N appears on outputs in cycle N+1 when stage was EMPTY or draining.
REQ-022 Order preserved; no pair duplicated or dropped except by flush.
REQ-023 Outputs SHALL stay stable while out_valid_o && !out_ready_i.
REQ-024 flush_i: next state EMPTY regardless of in/out activity that cycle; same-cycle input discarded; inst_o becomes ZERO_WORD, pc_o keeps last value.
REQ-025 flush_i and rst_n together: reset takes priority.

Reset
REQ-026 On rst_n high: state EMPTY, out_valid_o=0, in_ready_o=0 during reset and 1 the cycle after, pc_o=RESET_PC, inst_o=ZERO_WORD, skid cleared.
REQ-027 Reset mid-transfer discards both entries; no partial pair survives.

Configuration
REQ-028 Macro IF_ID_STAGE_SKID_EN defined: two-entry skid behaviour of REQ-016..REQ-020.
REQ-029 Macro undefined: single register only; states EMPTY/ONE; in_ready_o = !out_valid_o || out_ready_i (combinational); all other rules unchanged.

Structure
REQ-030 Shared package/defines file holds CPU_RESET_ADDR, ZERO_WORD, and state encodings IFID_EMPTY/IFID_ONE/IFID_FULL.
REQ-031 Single flat module; no sub-module — state logic is too small to split.

Verification
REQ-032 Reset: assert rst_n 2 cycles -> out_valid_o=0, pc_o=RESET_PC, inst_o=0x00000000; in_ready_o=1 next cycle.
REQ-033 Streaming: out_ready_i=1, feed pc 0x0,0x4,0x8 with inst 0x00000013 each cycle -> same sequence on outputs one cycle later, no bubbles.
REQ-034 Backpressure: out_ready_i=0 while feeding 0x10,0x14,0x18 -> in_ready_o falls after two accepts (skid build); release -> 0x10,0x14 emerge in order, 0x18 accepted then.
REQ-035 Flush while FULL: flush_i=1 with in_valid_i=1 pc 0x20 -> next cycle out_valid_o=0, inst_o=0, 0x20 never emitted.
REQ-036 Reset during backpressure with two entries held -> both dropped, outputs return to reset values.
REQ-037 Macro undefined build: rerun REQ-033/034 -> throughput unchanged, in_ready_o tracks out_ready_i combinationally when full.
